// File: rtl/pet_stats_engine_if.sv
// Action channel from the button decoder into the pet stat engine.
// Ports: act_valid/act_ready handshake, act_stat target index, act_op opcode
// (00 sub, 01 add, 10 set, 11 clear), act_amount operand (STAT_W bits).
interface pet_stats_engine_if #(
    parameter int STAT_W = 4
);
    logic              act_valid;
    logic              act_ready;
    logic [3:0]        act_stat;
    logic [1:0]        act_op;
    logic [STAT_W-1:0] act_amount;

    // Button decoder side.
    modport master (
        output act_valid,
        output act_stat,
        output act_op,
        output act_amount,
        input  act_ready
    );

    // Stat engine side.
    modport slave (
        input  act_valid,
        input  act_stat,
        input  act_op,
        input  act_amount,
        output act_ready
    );
endinterface

// File: rtl/pet_stats_engine.sv
// Purpose: NUM_STATS saturating pet stats, random drift on a programmable tick, adjusted by actions.
// Latency: accepted action or drift lands on the next clock edge; act_err pulses the cycle after acceptance.
// Backpressure: act_ready drops for exactly one cycle per tick while the pending drift is applied.
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   pause            - freezes the tick counter; actions and an already pending drift still proceed
//   random           - LFSR value, low bits pick the drift target in the tick cycle
//   act              - action channel (slave side of pet_stats_engine_if)
//   stats            - packed stat vector, stat i at [i*STAT_W +: STAT_W]
//   alarm            - bit i set while stat i >= ALARM_LEVEL
//   tick             - high during the cycle the tick counter wraps
//   act_err          - one-cycle pulse after an action with an out-of-range index is accepted
module pet_stats_engine #(
    parameter int NUM_STATS   = 6,
    parameter int STAT_W      = 4,
    parameter int TICK_DIV    = 1000,
    parameter int DRIFT_STEP  = 1,
    parameter int RESET_VAL   = 0,
    parameter int ALARM_LEVEL = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pause,
    input  logic [7:0]                  random,
    pet_stats_engine_if.slave           act,
    output logic [NUM_STATS*STAT_W-1:0] stats,
    output logic [NUM_STATS-1:0]        alarm,
    output logic                        tick,
    output logic                        act_err
);

    localparam int SEL_W = $clog2(NUM_STATS);
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [STAT_W-1:0] STAT_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_RST  = STAT_W'(RESET_VAL);
    // A drift step larger than the stat range simply saturates, so clip it once here.
    localparam logic [STAT_W-1:0] DRIFT_AMT =
        STAT_W'((DRIFT_STEP >= 2**STAT_W) ? (2**STAT_W - 1) : DRIFT_STEP);
    // One extra bit so a threshold just above the stat range means "never alarm".
    localparam logic [STAT_W:0]   ALARM_THR =
        (STAT_W+1)'((ALARM_LEVEL > 2**STAT_W) ? 2**STAT_W : ALARM_LEVEL);

    localparam logic [1:0] OP_SUB = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic [CNT_W-1:0]  tick_cnt;
    logic              drift_pend;
    logic [SEL_W-1:0]  drift_sel;
    logic [STAT_W-1:0] stat_q [NUM_STATS];
    logic [STAT_W-1:0] stat_d [NUM_STATS];
    logic              act_fire;
    logic              act_bad;

    // Only the low SEL_W bits of the LFSR select the drift target.
    logic unused_random;
    assign unused_random = ^random[7:SEL_W];

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[STAT_W] ? STAT_MAX : sum[STAT_W-1:0];
    endfunction

    // Borrow out of the STAT_W+1 bit difference means the result went negative.
    function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[STAT_W] ? '0 : diff[STAT_W-1:0];
    endfunction

    // The drift cycle is the only cycle the engine refuses actions, which keeps
    // drift and action updates mutually exclusive.
    assign act.act_ready = ~drift_pend;
    assign act_fire      = act.act_valid & ~drift_pend;
    assign act_bad       = ({1'b0, act.act_stat} >= 5'(NUM_STATS));
    assign tick          = (tick_cnt == CNT_LAST) & ~pause;

    always_comb begin
        for (int i = 0; i < NUM_STATS; i++) begin
            stat_d[i] = stat_q[i];
            if (drift_pend) begin
                // Selectors at or beyond NUM_STATS never match: the tick is consumed.
                if (drift_sel == SEL_W'(i)) begin
                    stat_d[i] = sat_add(stat_q[i], DRIFT_AMT);
                end
            end else if (act_fire && (act.act_stat == 4'(i))) begin
                case (act.act_op)
                    OP_SUB:  stat_d[i] = sat_sub(stat_q[i], act.act_amount);
                    OP_ADD:  stat_d[i] = sat_add(stat_q[i], act.act_amount);
                    OP_SET:  stat_d[i] = act.act_amount;
                    OP_CLR:  stat_d[i] = '0;
                    default: stat_d[i] = stat_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt   <= '0;
            drift_pend <= 1'b0;
            drift_sel  <= '0;
            act_err    <= 1'b0;
            for (int i = 0; i < NUM_STATS; i++) begin
                stat_q[i] <= STAT_RST;
            end
        end else begin
            if (!pause) begin
                tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            end
            // TICK_DIV >= 2 guarantees a tick never lands while a drift is pending.
            if (tick) begin
                drift_pend <= 1'b1;
                drift_sel  <= random[SEL_W-1:0];
            end else if (drift_pend) begin
                drift_pend <= 1'b0;
            end
            act_err <= act_fire & act_bad;
            for (int i = 0; i < NUM_STATS; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_STATS; g++) begin : g_out
            assign stats[g*STAT_W +: STAT_W] = stat_q[g];
            assign alarm[g]                  = ({1'b0, stat_q[g]} >= ALARM_THR);
        end
    endgenerate

endmodule
